// File: rtl/hamming_decoder.sv
// Two-stage Hamming (12,8) SEC decoder with valid/ready handshake and
// saturating corrected/uncorrectable word counters.
module hamming_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [11:0]      i_in,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [7:0]       o_out,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [3:0]       o_syndrome,
  output logic             o_corrected,
  output logic             o_uncorr,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_corr_cnt,
  output logic [CNT_W-1:0] o_uncorr_cnt
);

  function automatic logic [3:0] calc_syndrome(input logic [11:0] cw);
    calc_syndrome = {^{cw[7], cw[8], cw[9], cw[10], cw[11]},
                     ^{cw[3], cw[4], cw[5], cw[6], cw[11]},
                     ^{cw[1], cw[2], cw[5], cw[6], cw[9], cw[10]},
                     ^{cw[0], cw[2], cw[4], cw[6], cw[8], cw[10]}};
  endfunction

  function automatic logic [7:0] extract_data(input logic [11:0] cw);
    extract_data = {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic        adv_s;
  logic        s1_valid_r;
  logic [11:0] s1_cw_r;
  logic [3:0]  s1_syn_r;
  logic [11:0] flip_mask_s;
  logic [7:0]  fixed_data_s;
  logic        corr_s;
  logic        uncorr_s;

  assign adv_s   = ~o_valid | i_ready;
  assign o_ready = adv_s;

  // Classify the stage-1 syndrome and build the corrected data word.
  always_comb begin
    flip_mask_s = 12'h000;
    corr_s      = 1'b0;
    uncorr_s    = 1'b0;
    case (s1_syn_r)
      4'd0: begin
        flip_mask_s = 12'h000;
      end
      4'd13, 4'd14, 4'd15: begin
        uncorr_s = s1_valid_r;
      end
      default: begin
        flip_mask_s = 12'h001 << (s1_syn_r - 4'd1);
        corr_s      = s1_valid_r;
      end
    endcase
    fixed_data_s = extract_data(s1_cw_r ^ flip_mask_s);
  end

  // Pipeline stages; both advance together or both hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_cw_r     <= 12'h000;
      s1_syn_r    <= 4'h0;
      o_valid     <= 1'b0;
      o_out       <= 8'h00;
      o_syndrome  <= 4'h0;
      o_corrected <= 1'b0;
      o_uncorr    <= 1'b0;
    end else if (adv_s) begin
      s1_valid_r  <= i_valid;
      s1_cw_r     <= i_in;
      s1_syn_r    <= calc_syndrome(i_in);
      o_valid     <= s1_valid_r;
      o_out       <= fixed_data_s;
      o_syndrome  <= s1_syn_r;
      o_corrected <= corr_s;
      o_uncorr    <= uncorr_s;
    end
  end

  // Event counters; a clear wins over a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_corr_cnt   <= {CNT_W{1'b0}};
      o_uncorr_cnt <= {CNT_W{1'b0}};
    end else if (i_cnt_clr) begin
      o_corr_cnt   <= {CNT_W{1'b0}};
      o_uncorr_cnt <= {CNT_W{1'b0}};
    end else if (adv_s) begin
      if (corr_s) begin
        o_corr_cnt <= sat_inc(o_corr_cnt);
      end
      if (uncorr_s) begin
        o_uncorr_cnt <= sat_inc(o_uncorr_cnt);
      end
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: a positional Hamming model predicts
// each word, a monitor checks outputs as the decoder delivers them.
module tb_hamming_decoder;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] s;
    logic       c;
    logic       u;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [11:0] i_in = 12'h000;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic        i_cnt_clr = 1'b0;
  logic        o_ready, o_valid, o_corrected, o_uncorr;
  logic [7:0]  o_out;
  logic [3:0]  o_syndrome;
  logic [15:0] o_corr_cnt, o_uncorr_cnt;
  logic        o2_ready, o2_valid, o2_corrected, o2_uncorr;
  logic [7:0]  o2_out;
  logic [3:0]  o2_syndrome;
  logic [1:0]  o2_corr_cnt, o2_uncorr_cnt;

  hamming_decoder #(.CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_in(i_in), .i_valid(i_valid),
    .o_ready(o_ready), .o_out(o_out), .o_valid(o_valid), .i_ready(i_ready),
    .o_syndrome(o_syndrome), .o_corrected(o_corrected), .o_uncorr(o_uncorr),
    .i_cnt_clr(i_cnt_clr), .o_corr_cnt(o_corr_cnt), .o_uncorr_cnt(o_uncorr_cnt));

  hamming_decoder #(.CNT_W(2)) dut_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_in(i_in), .i_valid(i_valid),
    .o_ready(o2_ready), .o_out(o2_out), .o_valid(o2_valid), .i_ready(i_ready),
    .o_syndrome(o2_syndrome), .o_corrected(o2_corrected), .o_uncorr(o2_uncorr),
    .i_cnt_clr(i_cnt_clr), .o_corr_cnt(o2_corr_cnt), .o_uncorr_cnt(o2_uncorr_cnt));

  always #5 i_clk = ~i_clk;

  int   checks = 0;
  int   errors = 0;
  int   m_corr = 0;
  int   m_unc  = 0;
  exp_t sb[$];
  bit   bp_rand = 1'b0;
  bit   bp_hold = 1'b0;
  int   dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Data bits go to non-power-of-two positions; parity makes XOR of set positions zero.
  function automatic logic [11:0] enc(input logic [7:0] d);
    logic [11:0] cw;
    int          s;
    cw = 12'h000;
    s  = 0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) begin
        cw[dpos[i]-1] = 1'b1;
        s = s ^ dpos[i];
      end
    end
    for (int b = 0; b < 4; b++) begin
      if (s[b]) cw[(1 << b) - 1] = 1'b1;
    end
    return cw;
  endfunction

  function automatic exp_t model_dec(input logic [11:0] cw_in);
    logic [11:0] cw;
    int          s;
    exp_t        e;
    cw = cw_in;
    s  = 0;
    for (int k = 0; k < 12; k++) begin
      if (cw[k]) s = s ^ (k + 1);
    end
    if (s >= 1 && s <= 12) cw[s-1] = ~cw[s-1];
    for (int i = 0; i < 8; i++) e.d[i] = cw[dpos[i]-1];
    e.s = 4'(s);
    e.c = (s >= 1 && s <= 12);
    e.u = (s >= 13);
    return e;
  endfunction

  task automatic send_exp(input logic [11:0] cw, input exp_t e);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    i_in    = cw;
    i_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back(e);
      m_corr += int'(e.c);
      m_unc  += int'(e.u);
    end
  endtask

  task automatic send(input logic [11:0] cw);
    send_exp(cw, model_dec(cw));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("drain_left", sb.size(), 32'd0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_corr_cnt"}, o_corr_cnt, m_corr);
    chk({tag, "_uncorr_cnt"}, o_uncorr_cnt, m_unc);
    chk({tag, "_sat_corr"}, o2_corr_cnt, (m_corr > 3) ? 3 : m_corr);
    chk({tag, "_sat_unc"}, o2_uncorr_cnt, (m_unc > 3) ? 3 : m_unc);
  endtask

  task automatic clear_counts();
    i_cnt_clr = 1'b1;
    @(posedge i_clk);
    #1;
    i_cnt_clr = 1'b0;
    m_corr = 0;
    m_unc  = 0;
  endtask

  // Downstream ready driver.
  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      if (bp_hold) i_ready = 1'b0;
      else if (bp_rand) i_ready = 1'($urandom_range(0, 1));
      else i_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    exp_t        e;
    bit          held;
    logic [14:0] held_val;
    held = 1'b0;
    held_val = 15'h0000;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        held = 1'b0;
      end else begin
        if (held) chk("stall_hold", {o_valid, o_out, o_syndrome, o_corrected, o_uncorr}, held_val);
        if (o_valid && i_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("out_data", o_out, e.d);
            chk("out_syndrome", o_syndrome, e.s);
            chk("out_flags", {o_corrected, o_uncorr}, {e.c, e.u});
          end
        end
        held = o_valid && !i_ready;
        held_val = {o_valid, o_out, o_syndrome, o_corrected, o_uncorr};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [11:0] w;
    exp_t        e;
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_out", {o_out, o_syndrome, o_corrected, o_uncorr}, 14'h0000);
    chk("rst_cnt", {o_corr_cnt, o_uncorr_cnt}, 32'h0);
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("post_rst_ready", o_ready, 1'b1);

    // Directed vectors, with independently stated expectations.
    chk("enc_a5", enc(8'hA5), 12'hA27);
    send_exp(12'hA27, '{8'hA5, 4'h0, 1'b0, 1'b0});
    send_exp(12'hA07, '{8'hA5, 4'h6, 1'b1, 1'b0});
    send_exp(12'hAA7, '{8'hA5, 4'h8, 1'b1, 1'b0});
    send_exp(12'h223, '{8'h24, 4'hF, 1'b0, 1'b1});
    drain();
    chk("dir_corr_cnt", o_corr_cnt, 32'd2);
    chk("dir_uncorr_cnt", o_uncorr_cnt, 32'd1);

    // Every single-bit flip of every data value, streamed back-to-back.
    clear_counts();
    check_counts("clr");
    for (int d = 0; d < 256; d++) begin
      for (int k = 0; k < 12; k++) begin
        w = enc(8'(d)) ^ (12'h001 << k);
        e = '{8'(d), 4'(k + 1), 1'b1, 1'b0};
        send_exp(w, e);
      end
    end
    drain();
    chk("exh_corr_cnt", o_corr_cnt, 32'd3072);
    chk("exh_sat_cnt", o2_corr_cnt, 32'd3);
    check_counts("exh");

    // Clear coinciding with an increment.
    clear_counts();
    send(12'hA07);
    i_cnt_clr = 1'b1;
    @(posedge i_clk);
    #1;
    i_cnt_clr = 1'b0;
    m_corr = 0;
    chk("clr_inc_valid", o_valid, 1'b1);
    chk("clr_inc_cnt", o_corr_cnt, 32'd0);
    chk("clr_inc_sat", o2_corr_cnt, 32'd0);
    drain();

    // Random codewords under random backpressure and idle gaps.
    bp_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      send(12'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge i_clk);
        #1;
      end
    end
    bp_rand = 1'b0;
    drain();
    check_counts("rand");

    // Hold ready low with three words offered.
    bp_hold = 1'b1;
    @(posedge i_clk);
    #3;
    fork
      begin
        send(12'h5C3);
        send(12'h0F0);
        send(12'hA27);
      end
    join_none
    repeat (5) @(posedge i_clk);
    #3;
    chk("bp_ready_low", o_ready, 1'b0);
    chk("bp_valid", o_valid, 1'b1);
    chk("bp_out_first", o_out, model_dec(12'h5C3).d);
    bp_hold = 1'b0;
    wait fork;
    drain();
    check_counts("bp");

    // Reset with two words in flight.
    send(12'hA27);
    send(12'hA07);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_ready", o_ready, 1'b1);
    chk("mid_rst_out", {o_out, o_syndrome, o_corrected, o_uncorr}, 14'h0000);
    chk("mid_rst_cnt", {o_corr_cnt, o_uncorr_cnt}, 32'h0);
    sb.delete();
    m_corr = 0;
    m_unc  = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("post_mid_rst_valid", o_valid, 1'b0);
    send_exp(12'hAA7, '{8'hA5, 4'h8, 1'b1, 1'b0});
    drain();
    check_counts("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
